// File: rtl/evt_fifo_arbiter.sv
// evt_fifo_arbiter: round-robin arbiter sharing the single write port of the
// event sync FIFO among NREQ event producers. The winning word is registered
// onto the FIFO write port one cycle after acceptance.
//
// Handshake: an event moves from requester i in any cycle where
// req_valid[i] && req_ready[i]. req_ready may depend combinationally on
// req_valid, but a requester must never make req_valid depend on req_ready.
module evt_fifo_arbiter #(
    parameter int  NREQ   = 4,
    parameter int  DWIDTH = 136,
    parameter int  DEPTH  = 16,
    parameter int  CW     = 16,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_wdata,
    input  logic                     fifo_full,
    input  logic [AW-1:0]            fifo_numel,
    output logic [IW-1:0]            grant_id,
    output logic [CW-1:0]            stall_cnt,
    input  logic                     stall_clr
);

    logic              fifo_wr_en_q, fifo_wr_en_d;
    logic [DWIDTH-1:0] fifo_wdata_q, fifo_wdata_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     stall_cnt_q, stall_cnt_d;

    logic [AW:0]       occ;
    logic [AW+1:0]     occ_sum;
    logic              space;
    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand;
    logic              accept;
    logic              stall_cond;
    logic [DWIDTH-1:0] sel_data;

    // Conservative occupancy: the registered write counts as occupied and
    // FIFO reads are ignored, so an accepted event always finds room.
    always_comb begin
        occ     = fifo_full ? (AW+1)'(DEPTH) : {1'b0, fifo_numel};
        occ_sum = {1'b0, occ} + {{(AW+1){1'b0}}, fifo_wr_en_q};
        space   = occ_sum < (AW+2)'(DEPTH);
    end

    // Round-robin scan starting just after the last accepted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Accept decision, one-hot ready and selection of the winning word.
    always_comb begin
        accept     = grant_found && en && space && !rst;
        stall_cond = (|req_valid) && en && !space;
        req_ready  = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_data = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Next-state: write port, round-robin pointer and saturating stall counter.
    always_comb begin
        fifo_wr_en_d = accept;
        fifo_wdata_d = accept ? sel_data : fifo_wdata_q;
        last_d       = accept ? grant_idx : last_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (stall_cond && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers; reset discards any registered, not-yet-written event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en_q <= 1'b0;
            fifo_wdata_q <= '0;
            last_q       <= IW'(NREQ - 1);
            stall_cnt_q  <= '0;
        end else begin
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_wdata_q <= fifo_wdata_d;
            last_q       <= last_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_wdata = fifo_wdata_q;
    assign grant_id   = last_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_evt_fifo_arbiter.sv
// tb_evt_fifo_arbiter: directed bench for evt_fifo_arbiter with a small
// FIFO occupancy model on the write port.
module tb_evt_fifo_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 136;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wdata;
    logic              fifo_full;
    logic [3:0]        fifo_numel;
    logic [1:0]        grant_id;
    logic [CW-1:0]     stall_cnt;
    logic              stall_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];

    // FIFO model: count of stored words, reads only when non-empty.
    logic [4:0] cnt;
    logic       rd_en = 1'b0;

    assign fifo_full  = (cnt == 5'd16);
    assign fifo_numel = cnt[3:0];

    // clock/reset block
    always #5 clk = ~clk;

    // FIFO occupancy model
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + {4'd0, fifo_wr_en} - {4'd0, (rd_en && cnt != 5'd0)};
    end

    // Write-while-full invariant, checked every cycle
    always @(negedge clk) begin
        checks++;
        assert (!(fifo_wr_en && fifo_full))
        else begin
            errors++;
            $display("FAIL wr_while_full: wr_en=%b full=%b at %0t", fifo_wr_en, fifo_full, $time);
        end
    end

    evt_fifo_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .fifo_numel(fifo_numel),
        .grant_id(grant_id), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    function automatic logic [DW-1:0] mk(input int i, input int n);
        mk = {8'(i + 1), 16'(n), 112'(n * 131 + i * 7) ^ 112'hA5A5_5A5A_F00D_CAFE_1234};
    endfunction

    // driver tasks
    task automatic drive_data(input int n);
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mk(i, n);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en = 1'b0;
        req_valid = '0;
        stall_clr = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        drive_data(0);
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", fifo_wr_en); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", fifo_wdata); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant_id got=%0d exp=3", grant_id); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0]    exp_r;
        logic [DW-1:0] exp_d;
        int            exp_id;
        exp_q.delete();
        rd_en = 1'b1;
        en = 1'b1;
        req_valid = 4'b1111;
        exp_id = 0;
        for (int k = 0; k < 9; k++) begin
            drive_data(100 + k);
            @(negedge clk);
            exp_r = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_r); end
            checks++; if (fifo_wr_en !== (k > 0)) begin errors++; $display("FAIL rr_wr_en k=%0d got=%b exp=%b", k, fifo_wr_en, (k > 0)); end
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++; if (fifo_wdata !== exp_d) begin errors++; $display("FAIL rr_wdata k=%0d got=%h exp=%h", k, fifo_wdata, exp_d); end
                checks++; if (grant_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_grant_id k=%0d got=%0d exp=%0d", k, grant_id, exp_id); end
            end
            exp_q.push_back(mk(k % 4, 100 + k));
            exp_id = k % 4;
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        exp_d = exp_q.pop_front();
        checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rr_last_wr_en got=%b exp=1", fifo_wr_en); end
        checks++; if (fifo_wdata !== exp_d) begin errors++; $display("FAIL rr_last_wdata got=%h exp=%h", fifo_wdata, exp_d); end
        next_cycle();
    endtask

    task automatic test_single();
        int writes = 0;
        rd_en = 1'b1;
        en = 1'b1;
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            drive_data(200 + k);
            @(negedge clk);
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready k=%0d got=%b exp=0100", k, req_ready); end
            if (fifo_wr_en) writes++;
            if (k > 0) begin
                checks++; if (fifo_wdata !== mk(2, 199 + k)) begin errors++; $display("FAIL single_wdata k=%0d got=%h exp=%h", k, fifo_wdata, mk(2, 199 + k)); end
                checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id k=%0d got=%0d exp=2", k, grant_id); end
            end
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        if (fifo_wr_en) writes++;
        checks++; if (fifo_wdata !== mk(2, 209)) begin errors++; $display("FAIL single_last_wdata got=%h exp=%h", fifo_wdata, mk(2, 209)); end
        checks++; if (writes != 10) begin errors++; $display("FAIL single_writes got=%0d exp=10", writes); end
        next_cycle();
    endtask

    task automatic test_fill();
        logic [3:0] exp_r;
        int         writes = 0;
        int         exp_s;
        apply_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        for (int t = 0; t < 24; t++) begin
            drive_data(300 + t);
            @(negedge clk);
            exp_r = (t < 16) ? (4'b0001 << (t % 4)) : 4'b0000;
            exp_s = (t > 16) ? t - 16 : 0;
            checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL fill_ready t=%0d got=%b exp=%b", t, req_ready, exp_r); end
            checks++; if (stall_cnt !== CW'(exp_s)) begin errors++; $display("FAIL fill_stall t=%0d got=%0d exp=%0d", t, stall_cnt, exp_s); end
            if (fifo_wr_en) writes++;
            next_cycle();
        end
        checks++; if (writes != 16) begin errors++; $display("FAIL fill_writes got=%0d exp=16", writes); end
        checks++; if (cnt !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", cnt); end
        // cycle 24: clear while still stalling
        stall_clr = 1'b1;
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd8) begin errors++; $display("FAIL clr_before got=%0d exp=8", stall_cnt); end
        next_cycle();
        stall_clr = 1'b0;
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_zero got=%0d exp=0", stall_cnt); end
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL clr_restart got=%0d exp=1", stall_cnt); end
        for (int t = 0; t < 2; t++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_en_off t=%0d got=%0d exp=1", t, stall_cnt); end
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        apply_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        for (int t = 0; t < 16; t++) begin
            drive_data(400 + t);
            @(negedge clk);
            if (fifo_wr_en) writes++;
            next_cycle();
        end
        // cycle 16: occupancy 15 with a write pending, one read issued
        rd_en = 1'b1;
        drive_data(416);
        @(negedge clk);
        if (fifo_wr_en) writes++;
        checks++; if (fifo_numel !== 4'd15 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL b2b_setup numel=%0d wr_en=%b exp=15/1", fifo_numel, fifo_wr_en); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL b2b_no_grant got=%b exp=0000", req_ready); end
        next_cycle();
        rd_en = 1'b0;
        drive_data(417);
        @(negedge clk);
        if (fifo_wr_en) writes++;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_grant got=%b exp=0001", req_ready); end
        next_cycle();
        drive_data(418);
        @(negedge clk);
        if (fifo_wr_en) writes++;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL b2b_restall got=%b exp=0000", req_ready); end
        checks++; if (fifo_wdata !== mk(0, 417) || grant_id !== 2'd0) begin errors++; $display("FAIL b2b_wdata got=%h id=%0d exp=%h id=0", fifo_wdata, grant_id, mk(0, 417)); end
        next_cycle();
        @(negedge clk);
        if (fifo_wr_en) writes++;
        checks++; if (cnt !== 5'd16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", cnt); end
        checks++; if (writes != 17) begin errors++; $display("FAIL b2b_writes got=%0d exp=17", writes); end
        next_cycle();
    endtask

    task automatic test_enable();
        apply_reset();
        rd_en = 1'b1;
        en = 1'b1;
        req_valid = 4'b1111;
        for (int t = 0; t < 2; t++) begin
            drive_data(500 + t);
            next_cycle();
        end
        en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            drive_data(502 + t);
            @(negedge clk);
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_ready t=%0d got=%b exp=0000", t, req_ready); end
            checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL en_stall t=%0d got=%0d exp=0", t, stall_cnt); end
            checks++; if (fifo_wr_en !== (t == 0)) begin errors++; $display("FAIL en_wr_en t=%0d got=%b exp=%b", t, fifo_wr_en, (t == 0)); end
            checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL en_grant_id t=%0d got=%0d exp=1", t, grant_id); end
            next_cycle();
        end
        en = 1'b1;
        drive_data(507);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL en_resume got=%b exp=0100", req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (fifo_wdata !== mk(2, 507) || grant_id !== 2'd2) begin errors++; $display("FAIL en_resume_wdata got=%h id=%0d exp=%h id=2", fifo_wdata, grant_id, mk(2, 507)); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rd_en = 1'b1;
        en = 1'b1;
        req_valid = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            drive_data(600 + t);
            next_cycle();
        end
        checks++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL mid_pending wr_en=%b id=%0d exp=1/2", fifo_wr_en, grant_id); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en got=%b exp=0", fifo_wr_en); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mid_grant_id got=%0d exp=3", grant_id); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall got=%0d exp=0", stall_cnt); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL mid_wdata got=%h exp=0", fifo_wdata); end
        next_cycle();
        rst = 1'b0;
        drive_data(700);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== mk(0, 700)) begin errors++; $display("FAIL mid_first_write wr_en=%b got=%h exp=%h", fifo_wr_en, fifo_wdata, mk(0, 700)); end
        next_cycle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single();
        test_fill();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
